// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i core and its debug run-control logic.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    HALT_NONE       = 4'd0,
    HALT_DEBUG_REQ  = 4'd1,
    HALT_BREAKPOINT = 4'd2,
    HALT_STEP       = 4'd3,
    HALT_EBREAK     = 4'd4,
    HALT_RESET      = 4'd5
  } halt_cause_e;

  typedef enum logic [2:0] {
    ST_RUNNING   = 3'd0,
    ST_HALTING   = 3'd1,
    ST_HALTED    = 3'd2,
    ST_STEPPING  = 3'd3,
    ST_RESETTING = 3'd4
  } run_state_e;

endpackage

// File: rtl/dbg_bp_match.sv
// Two-comparator hardware breakpoint match on the issue PC; purely combinational.
module dbg_bp_match
  import rv32i_pkg::*;
(
  input  logic            issue_valid,
  input  logic [XLEN-1:0] issue_pc,
  input  logic            skip,
  input  logic [XLEN-1:0] bp0_addr,
  input  logic            bp0_en,
  input  logic [XLEN-1:0] bp1_addr,
  input  logic            bp1_en,
  output logic            hit
);

  logic match0;
  logic match1;

  assign match0 = bp0_en && (issue_pc == bp0_addr);
  assign match1 = bp1_en && (issue_pc == bp1_addr);
  assign hit    = issue_valid && !skip && (match0 || match1);

endmodule

// File: rtl/dbg_run_ctrl.sv
// Debug run-control sequencer: halt/resume/step/reset requests to core stall and reset.
module dbg_run_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 4,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dbg_halt_req,
  input  logic            dbg_resume_req,
  input  logic            dbg_step_req,
  input  logic            dbg_reset_req,
  input  logic [XLEN-1:0] bp0_addr,
  input  logic            bp0_en,
  input  logic [XLEN-1:0] bp1_addr,
  input  logic            bp1_en,
  input  logic            dbg_pc_we_in,
  input  logic            dbg_reg_we_in,
  input  logic            core_issue_valid,
  input  logic [XLEN-1:0] core_issue_pc,
  input  logic            core_retire,
  input  logic            core_idle,
  input  logic            core_ebreak,
  output logic            core_stall,
  output logic            core_rst_n,
  output logic            dbg_halted,
  output logic [3:0]      dbg_halt_cause,
  output logic            dbg_pc_we,
  output logic            dbg_reg_we
);

  localparam int unsigned      CNT_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  run_state_e       state;
  halt_cause_e      cause;
  logic             skip_bp;
  logic             step_issued;
  logic [CNT_W-1:0] rst_cnt;
  logic             bp_hit;
  logic             issue_fire;
  logic             reset_go;

  dbg_bp_match u_bp_match (
    .issue_valid (core_issue_valid),
    .issue_pc    (core_issue_pc),
    .skip        (skip_bp),
    .bp0_addr    (bp0_addr),
    .bp0_en      (bp0_en),
    .bp1_addr    (bp1_addr),
    .bp1_en      (bp1_en),
    .hit         (bp_hit)
  );

  // A hit must block issue in the same cycle, so stall stays combinational.
  always_comb begin
    core_stall = 1'b1;
    case (state)
      ST_RUNNING:  core_stall = bp_hit;
      ST_STEPPING: core_stall = step_issued;
      default:     core_stall = 1'b1;
    endcase
    if (!rst_n) core_stall = 1'b0;
  end

  assign issue_fire     = core_issue_valid && !core_stall;
  assign reset_go       = dbg_reset_req && (state != ST_RESETTING);
  assign dbg_pc_we      = dbg_pc_we_in && (state == ST_HALTED);
  assign dbg_reg_we     = dbg_reg_we_in && (state == ST_HALTED);
  assign dbg_halt_cause = cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUNNING;
      cause       <= HALT_NONE;
      skip_bp     <= 1'b0;
      step_issued <= 1'b0;
      rst_cnt     <= '0;
      core_rst_n  <= 1'b0;
      dbg_halted  <= 1'b0;
    end else begin
      if (state != ST_RESETTING) core_rst_n <= 1'b1;

      // Reset outranks every other request from any state but RESETTING.
      if (reset_go) begin
        state      <= ST_RESETTING;
        rst_cnt    <= CNT_LOAD;
        core_rst_n <= 1'b0;
        skip_bp    <= 1'b0;
        dbg_halted <= 1'b0;
      end else begin
        case (state)
          ST_RUNNING: begin
            if (issue_fire) skip_bp <= 1'b0;
            if (dbg_halt_req) begin
              state <= ST_HALTING;
              cause <= HALT_DEBUG_REQ;
            end else if (bp_hit) begin
              state <= ST_HALTING;
              cause <= HALT_BREAKPOINT;
            end else if (core_ebreak) begin
              state <= ST_HALTING;
              cause <= HALT_EBREAK;
            end
          end
          ST_HALTING: begin
            if (core_idle) begin
              state      <= ST_HALTED;
              dbg_halted <= 1'b1;
            end
          end
          ST_HALTED: begin
            // A halt request here is a no-op but still drops step/resume.
            if (!dbg_halt_req) begin
              if (dbg_step_req) begin
                state       <= ST_STEPPING;
                skip_bp     <= 1'b1;
                step_issued <= 1'b0;
                dbg_halted  <= 1'b0;
              end else if (dbg_resume_req) begin
                state      <= ST_RUNNING;
                skip_bp    <= 1'b1;
                cause      <= HALT_NONE;
                dbg_halted <= 1'b0;
              end
            end
          end
          ST_STEPPING: begin
            if (issue_fire) step_issued <= 1'b1;
            if (core_ebreak) begin
              state <= ST_HALTING;
              cause <= HALT_EBREAK;
            end else if (core_retire && step_issued) begin
              state <= ST_HALTING;
              cause <= HALT_STEP;
            end
          end
          ST_RESETTING: begin
            if (rst_cnt == CNT_LAST) begin
              core_rst_n <= 1'b1;
              if (HALT_ON_RESET) begin
                state      <= ST_HALTED;
                cause      <= HALT_RESET;
                dbg_halted <= 1'b1;
              end else begin
                state <= ST_RUNNING;
                cause <= HALT_NONE;
              end
            end else begin
              rst_cnt <= rst_cnt - CNT_LAST;
            end
          end
          default: state <= ST_RUNNING;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: two instances (run / halt after debug reset) against a behavioural model.
module tb_dbg_run_ctrl;

  localparam int unsigned RC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_req, resume_req, step_req, reset_req;
  logic [31:0] bp0_addr, bp1_addr, pc;
  logic        bp0_en, bp1_en, pc_we_in, reg_we_in, valid, retire, idle, ebreak;

  logic [1:0]  stall_o, crst_o, halted_o, pcwe_o, regwe_o;
  logic [3:0]  cause_o [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(.RESET_CYCLES(RC), .HALT_ON_RESET(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .dbg_halt_req(halt_req), .dbg_resume_req(resume_req),
    .dbg_step_req(step_req), .dbg_reset_req(reset_req),
    .bp0_addr(bp0_addr), .bp0_en(bp0_en), .bp1_addr(bp1_addr), .bp1_en(bp1_en),
    .dbg_pc_we_in(pc_we_in), .dbg_reg_we_in(reg_we_in),
    .core_issue_valid(valid), .core_issue_pc(pc), .core_retire(retire),
    .core_idle(idle), .core_ebreak(ebreak),
    .core_stall(stall_o[0]), .core_rst_n(crst_o[0]), .dbg_halted(halted_o[0]),
    .dbg_halt_cause(cause_o[0]), .dbg_pc_we(pcwe_o[0]), .dbg_reg_we(regwe_o[0])
  );

  dbg_run_ctrl #(.RESET_CYCLES(RC), .HALT_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .dbg_halt_req(halt_req), .dbg_resume_req(resume_req),
    .dbg_step_req(step_req), .dbg_reset_req(reset_req),
    .bp0_addr(bp0_addr), .bp0_en(bp0_en), .bp1_addr(bp1_addr), .bp1_en(bp1_en),
    .dbg_pc_we_in(pc_we_in), .dbg_reg_we_in(reg_we_in),
    .core_issue_valid(valid), .core_issue_pc(pc), .core_retire(retire),
    .core_idle(idle), .core_ebreak(ebreak),
    .core_stall(stall_o[1]), .core_rst_n(crst_o[1]), .dbg_halted(halted_o[1]),
    .dbg_halt_cause(cause_o[1]), .dbg_pc_we(pcwe_o[1]), .dbg_reg_we(regwe_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one set of flags per instance; index 1 halts after a debug reset.
  int m_left  [2];
  int m_cause [2];
  bit m_halting[2], m_halted[2], m_stepping[2], m_used[2], m_skip[2], m_boot[2];

  function automatic void m_clear(input int k);
    m_left[k] = 0; m_cause[k] = 0; m_halting[k] = 0; m_halted[k] = 0;
    m_stepping[k] = 0; m_used[k] = 0; m_skip[k] = 0; m_boot[k] = 0;
  endfunction

  function automatic bit m_hit(input int k);
    return valid && !m_skip[k] &&
           ((bp0_en && pc == bp0_addr) || (bp1_en && pc == bp1_addr));
  endfunction

  function automatic bit m_stall(input int k);
    if (!rst_n) return 1'b0;
    if (m_left[k] > 0 || m_halting[k] || m_halted[k]) return 1'b1;
    if (m_stepping[k]) return m_used[k];
    return m_hit(k);
  endfunction

  function automatic void m_step(input int k);
    bit issued;
    bit hit;
    issued = valid && !m_stall(k);
    hit    = m_hit(k);
    m_boot[k] = 1'b1;
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        if (k == 1) begin m_halted[k] = 1'b1; m_cause[k] = 5; end
        else m_cause[k] = 0;
      end
    end else if (reset_req) begin
      m_left[k] = RC; m_halting[k] = 0; m_halted[k] = 0; m_stepping[k] = 0; m_skip[k] = 0;
    end else if (m_halted[k]) begin
      if (halt_req) begin
      end else if (step_req) begin
        m_halted[k] = 0; m_stepping[k] = 1; m_used[k] = 0; m_skip[k] = 1;
      end else if (resume_req) begin
        m_halted[k] = 0; m_skip[k] = 1; m_cause[k] = 0;
      end
    end else if (m_halting[k]) begin
      if (idle) begin m_halting[k] = 0; m_halted[k] = 1; end
    end else if (m_stepping[k]) begin
      if (ebreak) begin
        m_stepping[k] = 0; m_halting[k] = 1; m_cause[k] = 4;
      end else if (retire && m_used[k]) begin
        m_stepping[k] = 0; m_halting[k] = 1; m_cause[k] = 3;
      end
      if (issued) m_used[k] = 1'b1;
    end else begin
      if (issued) m_skip[k] = 1'b0;
      if (halt_req)    begin m_halting[k] = 1; m_cause[k] = 1; end
      else if (hit)    begin m_halting[k] = 1; m_cause[k] = 2; end
      else if (ebreak) begin m_halting[k] = 1; m_cause[k] = 4; end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) m_clear(k);
    end else begin
      for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d stall", k),  {31'd0, stall_o[k]},  {31'd0, m_stall(k)});
      chk($sformatf("dut%0d core_rst_n", k), {31'd0, crst_o[k]},
          {31'd0, rst_n && m_boot[k] && m_left[k] == 0});
      chk($sformatf("dut%0d halted", k), {31'd0, halted_o[k]}, {31'd0, m_halted[k]});
      chk($sformatf("dut%0d cause", k),  {28'd0, cause_o[k]},  32'(m_cause[k]));
      chk($sformatf("dut%0d pc_we", k),  {31'd0, pcwe_o[k]},   {31'd0, pc_we_in && m_halted[k]});
      chk($sformatf("dut%0d reg_we", k), {31'd0, regwe_o[k]},  {31'd0, reg_we_in && m_halted[k]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    for (int k = 0; k < 2; k++) m_clear(k);
    rst_n = 1'b0;
    {halt_req, resume_req, step_req, reset_req} = '0;
    bp0_addr = '0; bp1_addr = '0; pc = '0;
    {bp0_en, bp1_en, reg_we_in, valid, retire, idle, ebreak} = '0;
    pc_we_in = 1'b1;

    @(posedge clk); look();
    chk("reset stall", {31'd0, stall_o[0]}, 32'd0);
    chk("reset core_rst_n", {31'd0, crst_o[0]}, 32'd0);
    chk("reset halted", {31'd0, halted_o[0]}, 32'd0);
    chk("reset cause", {28'd0, cause_o[1]}, 32'd0);
    chk("reset pc_we gated", {31'd0, pcwe_o[0]}, 32'd0);
    tick(); rst_n = 1'b1; pc_we_in = 1'b0;
    tick(); look();
    chk("core_rst_n after release", {31'd0, crst_o[0]}, 32'd1);

    // Write gating while running.
    tick(); pc_we_in = 1'b1; reg_we_in = 1'b1; look();
    chk("pc_we running", {31'd0, pcwe_o[0]}, 32'd0);
    chk("reg_we running", {31'd0, regwe_o[0]}, 32'd0);
    tick(); pc_we_in = 1'b0; reg_we_in = 1'b0;

    // Halt while running, idle three cycles later.
    valid = 1'b1; pc = 32'h40; halt_req = 1'b1; look();
    chk("stall on halt req cycle", {31'd0, stall_o[0]}, 32'd0);
    tick(); halt_req = 1'b0; look();
    chk("stall while halting", {31'd0, stall_o[0]}, 32'd1);
    tick();
    tick(); idle = 1'b1; look();
    chk("not halted before idle edge", {31'd0, halted_o[0]}, 32'd0);
    tick(); pc_we_in = 1'b1; look();
    chk("halted after idle", {31'd0, halted_o[0]}, 32'd1);
    chk("cause debug req", {28'd0, cause_o[0]}, 32'd1);
    chk("pc_we halted", {31'd0, pcwe_o[0]}, 32'd1);

    // Resume, then breakpoint on 0x100.
    tick(); pc_we_in = 1'b0; resume_req = 1'b1;
    tick(); resume_req = 1'b0; look();
    chk("running after resume", {31'd0, stall_o[0]}, 32'd0);
    chk("cause cleared", {28'd0, cause_o[0]}, 32'd0);
    tick(); bp0_addr = 32'h100; bp0_en = 1'b1; pc = 32'h100; look();
    chk("bp stall same cycle", {31'd0, stall_o[0]}, 32'd1);
    tick(); look();
    chk("cause breakpoint", {28'd0, cause_o[0]}, 32'd2);
    tick(); look();
    chk("halted at bp", {31'd0, halted_o[0]}, 32'd1);
    resume_req = 1'b1;
    tick(); resume_req = 1'b0; look();
    chk("0x100 issues after resume", {31'd0, stall_o[0]}, 32'd0);
    tick(); pc = 32'h104; look();
    chk("no stall at 0x104", {31'd0, stall_o[0]}, 32'd0);
    tick(); pc = 32'h100;
    tick();
    tick(); look();
    chk("halted at bp again", {28'd0, cause_o[0]}, 32'd2);

    // Single step from the breakpoint.
    step_req = 1'b1;
    tick(); step_req = 1'b0; look();
    chk("step issues 0x100", {31'd0, stall_o[0]}, 32'd0);
    chk("not halted stepping", {31'd0, halted_o[0]}, 32'd0);
    tick(); pc = 32'h104; look();
    chk("one issue per step", {31'd0, stall_o[0]}, 32'd1);
    retire = 1'b1;
    tick(); retire = 1'b0; look();
    chk("cause step", {28'd0, cause_o[0]}, 32'd3);
    tick(); look();
    chk("halted after step", {31'd0, halted_o[0]}, 32'd1);

    // Resume and step together: step wins.
    resume_req = 1'b1; step_req = 1'b1;
    tick(); resume_req = 1'b0; step_req = 1'b0; look();
    chk("step beats resume", {31'd0, stall_o[0]}, 32'd0);
    chk("cause kept stepping", {28'd0, cause_o[0]}, 32'd3);
    tick(); ebreak = 1'b1;
    tick(); ebreak = 1'b0; look();
    chk("cause ebreak", {28'd0, cause_o[0]}, 32'd4);
    tick();

    // Halt and step together while halted: halt is a no-op and drops step.
    halt_req = 1'b1; step_req = 1'b1;
    tick(); halt_req = 1'b0; step_req = 1'b0; look();
    chk("halt drops step", {31'd0, halted_o[0]}, 32'd1);
    resume_req = 1'b1;
    tick(); resume_req = 1'b0; pc = 32'h200;

    // Halt and reset together: reset wins; requests during reset are dropped.
    tick(); halt_req = 1'b1; reset_req = 1'b1;
    tick(); halt_req = 1'b0; reset_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      look();
      if (crst_o[0]) break;
      cnt++;
      halt_req = (cnt == 2);
      tick();
    end
    halt_req = 1'b0;
    chk("core_rst_n low cycles", 32'(cnt), 32'd4);
    chk("running after reset", {31'd0, stall_o[0]}, 32'd0);
    chk("not halted after reset", {31'd0, halted_o[0]}, 32'd0);
    chk("halt on reset halted", {31'd0, halted_o[1]}, 32'd1);
    chk("halt on reset cause", {28'd0, cause_o[1]}, 32'd5);

    // Bring both into STEPPING, then pulse rst_n.
    tick(); halt_req = 1'b1;
    tick(); halt_req = 1'b0;
    tick(); look();
    chk("dut0 halted by request", {31'd0, halted_o[0]}, 32'd1);
    step_req = 1'b1;
    tick(); step_req = 1'b0; pc_we_in = 1'b1; look();
    chk("pc_we stepping", {31'd0, pcwe_o[0]}, 32'd0);
    chk("pc_we stepping dut1", {31'd0, pcwe_o[1]}, 32'd0);
    tick(); rst_n = 1'b0; look();
    chk("async stall", {31'd0, stall_o[1]}, 32'd0);
    chk("async core_rst_n", {31'd0, crst_o[0]}, 32'd0);
    chk("async halted", {31'd0, halted_o[1]}, 32'd0);
    chk("async cause", {28'd0, cause_o[0]}, 32'd0);
    chk("async pc_we", {31'd0, pcwe_o[0]}, 32'd0);
    tick(); rst_n = 1'b1; pc_we_in = 1'b0;
    tick();
    tick();

    // Breakpoint 1 alone.
    bp0_en = 1'b0; bp1_addr = 32'h300; bp1_en = 1'b1; pc = 32'h300; look();
    chk("bp1 stall", {31'd0, stall_o[0]}, 32'd1);
    tick();
    tick(); look();
    chk("bp1 halted", {28'd0, cause_o[1]}, 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
